// File: rtl/rs_pkg.sv
// Shared definitions for the RS(15,9) decoder over GF(2^4).
package rs_pkg;

  localparam int GF_M  = 4;
  localparam int RS_N  = 15;
  localparam int RS_K  = 9;
  localparam int RS_T  = 3;
  localparam int NSYND = 2 * RS_T;

  localparam logic [GF_M:0] GF_POLY = 5'b10011;

  typedef logic [GF_M-1:0] gf_elem_t;

  // Six packed syndromes, S1 sits in index 0 (lowest nibble).
  typedef gf_elem_t [NSYND-1:0] synd_arr_t;

  typedef enum logic {IDLE, ACC} synd_state_t;

  // alpha^i for i = 0..14, where alpha = x (4'h2).
  localparam gf_elem_t ALPHA_POW [0:RS_N-1] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
    4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9
  };

  // Shift-and-add product; each doubling of a is reduced by the low bits of the polynomial.
  function automatic gf_elem_t gf_mul(input gf_elem_t a, input gf_elem_t b);
    gf_elem_t acc;
    gf_elem_t sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < GF_M; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[GF_M-2:0], 1'b0} ^ (sh[GF_M-1] ? GF_POLY[GF_M-1:0] : '0);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf16_mul.sv
// Combinational GF(2^4) multiplier, p = a * b mod x^4+x+1.
module gf16_mul
  import rs_pkg::*;
(
  input  gf_elem_t a,
  input  gf_elem_t b,
  output gf_elem_t p
);

  // Pure product; constant b collapses to a few XORs after synthesis.
  always_comb begin
    p = gf_mul(a, b);
  end

endmodule

// File: rtl/rs_syndrome_calc.sv
// Serial Horner-rule syndrome calculator for RS(15,9): S_j = r(alpha^j), j = 1..6.
module rs_syndrome_calc
  import rs_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int N_SYM      = 15,
  parameter int NSYND      = 6,
  parameter logic [4:0] GF_POLY = 5'b10011
)
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        sof,
  input  logic [DATA_WIDTH-1:0]       data_i,
  output logic                        busy,
  output logic                        rdy,
  output logic                        err,
  output logic [NSYND*DATA_WIDTH-1:0] data_o
);

  synd_state_t state_reg, state_next;
  logic [3:0]  cnt_reg;
  synd_arr_t   acc_reg;
  synd_arr_t   prod;
  synd_arr_t   final_synd;
  logic [NSYND*DATA_WIDTH-1:0] data_reg;
  logic        err_reg;
  logic        rdy_reg;

  logic start;
  logic step;
  logic last;

  // sof always (re)starts a block, even mid-block; plain en advances an open block.
  assign start = en && sof;
  assign step  = en && !sof && (state_reg == ACC);
  assign last  = step && (cnt_reg == 4'(N_SYM - 1));

  // One constant multiplier per syndrome: acc_j * alpha^j, then add the new symbol.
  generate
    for (genvar gi = 0; gi < NSYND; gi++) begin : g_mul
      gf16_mul u_mul (
        .a (acc_reg[gi]),
        .b (ALPHA_POW[gi+1]),
        .p (prod[gi])
      );
      assign final_synd[gi] = prod[gi] ^ data_i;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = ACC;
      ACC:  if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: busy while a block is being accumulated.
  always_comb begin
    busy = (state_reg == ACC);
  end

  // Accumulators and symbol counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (start) begin
      acc_reg <= {NSYND{data_i}};
      cnt_reg <= 4'd1;
    end else if (last) begin
      acc_reg <= final_synd;
      cnt_reg <= '0;
    end else if (step) begin
      acc_reg <= final_synd;
      cnt_reg <= cnt_reg + 4'd1;
    end
  end

  // Result register: captured on the 15th symbol, held until the next completed block.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg <= '0;
      err_reg  <= 1'b0;
      rdy_reg  <= 1'b0;
    end else begin
      rdy_reg <= last;
      if (last) begin
        data_reg <= final_synd;
        err_reg  <= |final_synd;
      end
    end
  end

  assign data_o = data_reg;
  assign err    = err_reg;
  assign rdy    = rdy_reg;

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Scoreboard bench for rs_syndrome_calc: driver pushes expectations, monitor pops on rdy.
module tb_rs_syndrome_calc;

  logic        clk;
  logic        rst;
  logic        en;
  logic        sof;
  logic [3:0]  data_i;
  logic        busy;
  logic        rdy;
  logic        err;
  logic [23:0] data_o;

  typedef struct {
    logic [23:0] data;
    logic        err;
    int          cyc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  rs_syndrome_calc dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .sof    (sof),
    .data_i (data_i),
    .busy   (busy),
    .rdy    (rdy),
    .err    (err),
    .data_o (data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) begin
      n_pass++;
      $display("check %-14s ok   value=%0h", name, act);
    end else begin
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every rdy pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rdy", 32'(rdy), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("rdy for block %s: data_o=%06h err=%0b cyc=%0d", e.name, data_o, err, cyc);
        check({e.name, "_data"}, 32'(data_o), 32'(e.data));
        check({e.name, "_err"},  32'(err),    32'(e.err));
        check({e.name, "_lat"},  32'(cyc),    32'(e.cyc));
      end
    end
  end

  task automatic idle_cycles(input int n);
    en  = 1'b0;
    sof = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_sym(input logic s, input logic [3:0] d, input int gap);
    idle_cycles(gap);
    en     = 1'b1;
    sof    = s;
    data_i = d;
    @(posedge clk);
    #1;
    en     = 1'b0;
    sof    = 1'b0;
  endtask

  // Full 15-symbol block; one_deg is the degree of the single 1 (or -1 for all-zero).
  task automatic send_block(input string name, input int one_deg, input int gapmax,
                            input logic [23:0] exp_d, input logic exp_e);
    exp_t e;
    for (int k = 0; k < 15; k++) begin
      int gap;
      gap = (k == 0 || gapmax == 0) ? 0 : int'($urandom_range(0, gapmax));
      send_sym(k == 0, (14 - k == one_deg) ? 4'h1 : 4'h0, gap);
      if (k == 0) check({name, "_busy"}, 32'(busy), 32'd1);
    end
    e.data = exp_d;
    e.err  = exp_e;
    e.cyc  = cyc;
    e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    sof    = 1'b0;
    data_i = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdy",  32'(rdy),  32'd0);
    check("rst_err",  32'(err),  32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    rst = 1'b0;
    idle_cycles(2);

    send_block("zero", -1, 0, 24'h000000, 1'b0);
    idle_cycles(3);
    send_block("r0",    0, 0, 24'h111111, 1'b1);
    idle_cycles(3);
    send_block("r1",    1, 0, 24'hC63842, 1'b1);
    idle_cycles(3);
    send_block("r1gap", 1, 5, 24'hC63842, 1'b1);
    idle_cycles(3);
    send_block("r14",  14, 0, 24'hA7EFD9, 1'b1);
    idle_cycles(3);

    // Partial block of ones, abandoned by a new sof.
    for (int k = 0; k < 7; k++) send_sym(k == 0, 4'h1, 0);
    send_block("restart", 0, 0, 24'h111111, 1'b1);
    // Next block starts with sof in the rdy cycle.
    send_block("b2b",    14, 0, 24'hA7EFD9, 1'b1);
    idle_cycles(3);

    // Reset at symbol 9 of a block.
    for (int k = 0; k < 8; k++) send_sym(k == 0, 4'h5, 0);
    en     = 1'b1;
    data_i = 4'h5;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    en  = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rdy",  32'(rdy),  32'd0);
    check("mid_rst_err",  32'(err),  32'd0);
    check("mid_rst_data", 32'(data_o), 32'd0);
    // Symbols without sof while idle are dropped.
    for (int k = 0; k < 16; k++) send_sym(1'b0, 4'h7, 0);
    check("nosof_busy", 32'(busy), 32'd0);
    send_block("post_rst", 1, 0, 24'hC63842, 1'b1);

    // Bounded drain of outstanding expectations.
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle_cycles(1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    idle_cycles(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rs_syndrome_calc.md
Name: rs_syndrome_calc

Overview:
- Front stage of the RS(15,9) decoder over GF(2^4).
- Takes a received 15-symbol codeword serially and computes the six syndromes S_j = r(alpha^j), j = 1..6, using Horner's rule.
- Results go to the key-equation / inverse stage downstream.
- Also flags whether the codeword contains any error.

Parameters:
- DATA_WIDTH, 4, symbol width m (GF(2^m)).
- N_SYM, 15, symbols per codeword.
- NSYND, 6, number of syndromes (2T).
- GF_POLY, 5'b10011, primitive polynomial x^4+x+1; alpha = 4'h2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high, sampled on rising edge of clk
- en  in  1  data_i valid this cycle
- sof  in  1  with en: data_i is the first symbol (r14) of a new codeword
- data_i  in  DATA_WIDTH  received symbol, highest degree (r14) first, r0 last
- busy  out  1  codeword accumulation in progress
- rdy  out  1  one-cycle pulse: data_o/err valid for a new block
- err  out  1  any syndrome nonzero
- data_o  out  NSYND*DATA_WIDTH  packed syndromes, S1 in [3:0] ... S6 in [23:20]

Behaviour:
- Reset: all accumulators = 0, symbol counter = 0, busy = 0, rdy = 0, err = 0, data_o = 0.
- Reset mid-block aborts the block; no rdy is produced for it.
- States: IDLE, ACC.
  - IDLE: en&sof -> ACC. Load S_j <= data_i for all j; cnt <= 1; busy <= 1.
  - IDLE: en without sof is ignored (symbol dropped).
  - ACC, on en: S_j <= gf_mul(S_j, alpha^j) XOR data_i; cnt <= cnt+1.
  - ACC, no en: hold (stalls/gaps of any length allowed).
  - ACC, en&sof: restart. Treat as the first symbol of a new block (same load as from IDLE); the partial block is discarded with no rdy.
  - ACC, en on the symbol where cnt == N_SYM-1 (the 15th symbol): register final syndromes into the data_o register, err <= |final syndromes, rdy <= 1 for the following cycle. Then cnt <= 0, busy <= 0, go to IDLE.
- Latency: rdy, data_o and err are valid the cycle after the 15th accepted symbol.
- data_o/err hold until the next completed block. Accumulators are separate from the output register, so a new block may start in the very cycle rdy is high (sof with en accepted in IDLE, back-to-back, no bubble).
- Arithmetic: all GF(2^4). Addition is XOR. Multiplication is a polynomial product reduced mod GF_POLY. The powers alpha^1..alpha^6 are constants: 2, 4, 8, 3, 6, C.
- Field elements are unsigned 4-bit; there is no integer arithmetic in this block.
- The counter is 4 bits and never wraps past 14 within a block.
- rdy never asserts twice for one block. It is 0 whenever busy rises.

Decomposition:
- Package rs_pkg:
  - constants GF_M=4, RS_N=15, RS_K=9, RS_T=3, GF_POLY, ALPHA_POW[0:14] (power table);
  - typedef gf_elem_t (logic [3:0]);
  - typedef synd_arr_t (gf_elem_t [NSYND]);
  - enum synd_state_t {IDLE, ACC}.
- The package is shared with the inverse and later stages.
- Sub-module gf16_mul: combinational GF(2^4) multiplier (a, b -> p). Instantiated NSYND times with constant b = alpha^j. It is reused by the Berlekamp/Forney stages.

Test Plan:
- All-zero codeword, 15 symbols back-to-back -> rdy one cycle after the 15th symbol, data_o = 24'h000000, err = 0.
- r0 = 1 (last symbol 1, others 0) -> data_o = 24'h111111, err = 1.
- r1 = 1 (14th symbol 1) -> data_o = 24'hC63842, err = 1. Repeat with random en gaps of 0-5 cycles between symbols -> identical result, rdy exactly once.
- r14 = 1 (first symbol 1) -> data_o = 24'hA7EFD9.
- Restart: 7 symbols of all 1, then a new sof block carrying the r0 = 1 pattern -> a single rdy, data_o = 24'h111111. Second block starts with sof in the rdy cycle -> both blocks reported, correct values.
- rst asserted at symbol 9 of a block -> busy, rdy, data_o, err all 0 next cycle. en without sof afterwards -> ignored. A following full block with r1 = 1 -> data_o = 24'hC63842.
